router_pkt_fifo: RTL and testbench

//   Parametrised packet-aware FIFO for the router output channels; next

---
 rtl/router_pkt_fifo.sv | 71 +++++++
 tb/tb_router_pkt_fifo.sv | 132 +++++++++++++
 2 files changed

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware channel FIFO with registered read port and
// read-side packet-length tracking (header length field plus parity byte).
module router_pkt_fifo #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int LEN_LSB = 2,
   parameter int LEN_W   = 6,
   parameter int AF_LVL  = DEPTH - 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       soft_reset,
   input  logic                       write_enb,
   input  logic                       lfd_state,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       read_enb,
   output logic [DATA_W-1:0]          data_out,
   output logic                       data_valid,
   output logic                       hdr_out,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       pkt_busy,
   output logic                       pkt_err
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LVL);
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [DATA_W:0]  mem [DEPTH];
   logic [DATA_W:0]  rd_word;
   logic [LEN_W:0]   pkt_remaining;
   logic             wr_ok, rd_ok, flush;
   assign flush       = reset || soft_reset;
   assign empty       = wr_ptr == rd_ptr;
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign almost_full = count >= AF_CNT;
   assign wr_ok       = write_enb && !full;
   assign rd_ok       = read_enb && !empty;
   assign rd_word     = mem[rd_ptr[AW-1:0]];
   assign pkt_busy    = pkt_remaining != '0;
   // storage is never cleared: stale entries are unreachable once pointers reset
   always_ff @(posedge clock)
      if (wr_ok && !flush) mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         pkt_remaining <= '0;
         data_out      <= '0;
         data_valid    <= 1'b0;
         hdr_out       <= 1'b0;
         pkt_err       <= 1'b0;
      end else begin
         data_valid <= rd_ok;
         if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
         count <= (wr_ok && !rd_ok) ? count + (AW+1)'(1) :
                  (rd_ok && !wr_ok) ? count - (AW+1)'(1) : count;
         if (rd_ok) begin
            data_out <= rd_word[DATA_W-1:0];
            hdr_out  <= rd_word[DATA_W];
            // header reloads with payload length plus the trailing parity byte
            pkt_remaining <= rd_word[DATA_W] ? {1'b0, rd_word[LEN_LSB+LEN_W-1:LEN_LSB]} + (LEN_W+1)'(1) :
                             pkt_busy ? pkt_remaining - (LEN_W+1)'(1) : pkt_remaining;
            if (rd_word[DATA_W] && pkt_busy) pkt_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed and randomized stimulus checked every cycle
// against a queue-based reference model of the packet FIFO.
module tb_router_pkt_fifo;
   logic       clock = 1'b0;
   logic       reset = 1'b0, soft_reset = 1'b0, write_enb = 1'b0, lfd_state = 1'b0, read_enb = 1'b0;
   logic [7:0] data_in = '0, data_out;
   logic       data_valid, hdr_out, empty, full, almost_full, pkt_busy, pkt_err;
   logic [4:0] count;
   int         checks = 0, errors = 0;
   logic [8:0] q[$];
   logic [7:0] m_dout;
   logic       m_hdr, m_valid, m_err;
   int         m_rem;

   router_pkt_fifo dut (
      .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
      .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
      .data_valid(data_valid), .hdr_out(hdr_out), .empty(empty), .full(full),
      .almost_full(almost_full), .count(count), .pkt_busy(pkt_busy), .pkt_err(pkt_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance the model by the FIFO rules, compare after the edge
   task automatic cyc(input logic rst, input logic sr, input logic we, input logic lfd,
                      input logic [7:0] din, input logic re);
      bit         rd, wr;
      logic [8:0] e;
      reset = rst; soft_reset = sr; write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
      rd = re && q.size() != 0;
      wr = we && q.size() != 16;
      if (rst || sr) begin
         q.delete();
         m_dout = '0; m_hdr = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_rem = 0;
      end else begin
         m_valid = rd;
         if (rd) begin
            e = q.pop_front();
            m_dout = e[7:0];
            m_hdr  = e[8];
            if (e[8]) begin
               if (m_rem != 0) m_err = 1'b1;
               m_rem = int'(e[7:2]) + 1;
            end else if (m_rem != 0) m_rem--;
         end
         if (wr) q.push_back({lfd, din});
      end
      @(posedge clock);
      #1;
      check("count", count, q.size());
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == 16);
      check("almost_full", almost_full, q.size() >= 14);
      check("data_valid", data_valid, m_valid);
      check("data_out", data_out, m_dout);
      check("hdr_out", hdr_out, m_hdr);
      check("pkt_busy", pkt_busy, m_rem != 0);
      check("pkt_err", pkt_err, m_err);
   endtask

   task automatic wr(input logic [7:0] d, input logic lfd);
      cyc(0, 0, 1, lfd, d, 0);
   endtask

   task automatic rd();
      cyc(0, 0, 0, 0, 8'h00, 1);
   endtask

   initial begin
      int written;
      bit we, re;
      cyc(1, 0, 0, 0, 8'h00, 0);
      cyc(0, 0, 0, 0, 8'h00, 0);
      // fill to full, one dropped write, drain in order
      for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
      wr(8'hAA, 1'b0);
      for (int i = 0; i < 16; i++) rd();
      rd();
      // header 0x0C: 3 payload bytes plus parity
      wr(8'h0C, 1'b1);
      for (int i = 0; i < 4; i++) wr(8'h50 + 8'(i), 1'b0);
      for (int i = 0; i < 5; i++) rd();
      // simultaneous read/write on full and on empty
      for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 1'b0);
      cyc(0, 0, 1, 0, 8'hEE, 1);
      for (int i = 0; i < 15; i++) rd();
      cyc(0, 0, 1, 0, 8'h77, 1);
      rd();
      // 40 words streamed with occupancy held in 3..14 to wrap the pointers
      written = 0;
      while (written < 40) begin
         we = q.size() < 14 && ($urandom_range(0, 3) != 0);
         re = q.size() > 3 && ($urandom_range(0, 1) != 0);
         cyc(0, 0, we, 0, 8'($urandom), re);
         if (we) written++;
      end
      while (q.size() != 0) rd();
      // soft reset mid-packet: header len 4 -> remaining 5, count 7 after header pop
      wr(8'h10, 1'b1);
      for (int i = 0; i < 7; i++) wr(8'h20 + 8'(i), 1'b0);
      rd();
      check("mid_count", count, 7);
      check("mid_busy", pkt_busy, 1);
      cyc(0, 1, 0, 0, 8'h00, 0);
      wr(8'h04, 1'b1);
      wr(8'h31, 1'b0);
      wr(8'h32, 1'b0);
      for (int i = 0; i < 3; i++) rd();
      // two headers back to back set a sticky error
      wr(8'h08, 1'b1);
      wr(8'h04, 1'b1);
      rd();
      rd();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h00, 0);
      check("err_sticky", pkt_err, 1);
      cyc(1, 0, 0, 0, 8'h00, 0);
      // randomized traffic with occasional headers and flushes
      for (int i = 0; i < 400; i++)
         cyc(0, $urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0,
             $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
